// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: op encoding, error codes,
// FSM state constants, and the size/byte-enable/alignment rules.
package lsu_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd3,
        LHU = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        MISALIGN = 2'd1,
        BUS      = 2'd2
    } lsu_err_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    typedef logic [1:0] lsu_state_e;
    localparam lsu_state_e IDLE = 2'd0;
    localparam lsu_state_e REQ  = 2'd1;
    localparam lsu_state_e WAIT = 2'd2;

    function automatic logic is_store(input lsu_op_e op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic lsu_size_e op_size(input lsu_op_e op);
        case (op)
            LB, LBU, SB: return SZ_BYTE;
            LH, LHU, SH: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] off);
        case (op_size(op))
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Loads assert the same lanes a store of the same width would.
    function automatic logic [3:0] byte_enable(input lsu_op_e op, input logic [1:0] off);
        case (op_size(op))
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Maps the ALU's load/store class bit plus funct3 onto the unit's op code.
    function automatic lsu_op_e decode_op(input logic store, input logic [2:0] funct3);
        if (store) begin
            case (funct3)
                3'b000:  return SB;
                3'b001:  return SH;
                default: return SW;
            endcase
        end
        case (funct3)
            3'b000:  return LB;
            3'b001:  return LH;
            3'b100:  return LBU;
            3'b101:  return LHU;
            default: return LW;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extractor: shifts the addressed lane down to bit 0 and sign- or
// zero-extends it according to the load width.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  lsu_op_e     op,
    output logic [31:0] result
);

    logic [31:0] lane;

    assign lane = rdata >> {offset, 3'b000};

    always_comb begin
        result = lane;
        case (op)
            LB:      result = {{24{lane[7]}}, lane[7:0]};
            LH:      result = {{16{lane[15]}}, lane[15:0]};
            LBU:     result = {24'b0, lane[7:0]};
            LHU:     result = {16'b0, lane[15:0]};
            default: result = lane;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: latches an execute-stage access, runs the req/gnt/rvalid
// handshake to data memory and returns an extended, tagged result.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid_i,
    input  lsu_op_e           ex_op_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic [XLEN-1:0]   ex_wdata_i,
    input  logic [4:0]        ex_rd_i,
    output logic              busy_o,
    output logic              data_req_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [XLEN-1:0]   data_wdata_o,
    input  logic              data_gnt_i,
    input  logic              data_rvalid_i,
    input  logic [XLEN-1:0]   data_rdata_i,
    input  logic              data_err_i,
    output logic              lsu_valid_o,
    output logic [XLEN-1:0]   lsu_rdata_o,
    output logic [4:0]        lsu_rd_o,
    output logic [1:0]        lsu_err_o
);

    lsu_state_e        state_reg, state_next;
    lsu_op_e           op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [XLEN-1:0]   wdata_reg;
    logic [3:0]        be_reg;
    logic              we_reg;
    logic [4:0]        rd_reg;

    logic              valid_reg;
    logic [XLEN-1:0]   rdata_reg;
    logic [4:0]        lrd_reg;
    lsu_err_e          err_reg;

    lsu_size_e         ex_size;
    logic              ex_misaligned;
    logic [XLEN-1:0]   wdata_rep;
    logic [XLEN-1:0]   load_result;

    assign ex_size       = op_size(ex_op_i);
    assign ex_misaligned = is_misaligned(ex_op_i, ex_addr_i[1:0]);

    // Store data is replicated across every lane it could land in, so the
    // byte enables alone select the destination bytes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata_rep[8*gi +: 8] =
            (ex_size == SZ_BYTE) ? ex_wdata_i[7:0] :
            (ex_size == SZ_HALF) ? ex_wdata_i[8*(gi%2) +: 8] :
                                   ex_wdata_i[8*gi +: 8];
    end

    lsu_load_align u_load_align (
        .rdata  (data_rdata_i),
        .offset (addr_reg[1:0]),
        .op     (op_reg),
        .result (load_result)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ex_valid_i && !ex_misaligned) state_next = REQ;
            REQ:     if (data_gnt_i)                   state_next = WAIT;
            WAIT:    if (data_rvalid_i)                state_next = IDLE;
            default:                                   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            op_reg    <= LB;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
            we_reg    <= 1'b0;
            rd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && ex_valid_i) begin
                op_reg    <= ex_op_i;
                addr_reg  <= ex_addr_i;
                wdata_reg <= wdata_rep;
                be_reg    <= byte_enable(ex_op_i, ex_addr_i[1:0]);
                we_reg    <= is_store(ex_op_i);
                rd_reg    <= ex_rd_i;
            end
        end
    end

    // Completion path: misaligned ops finish straight from IDLE, memory ops
    // finish on the response; either way the pulse lasts a single cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            rdata_reg <= '0;
            lrd_reg   <= '0;
            err_reg   <= NONE;
        end else begin
            valid_reg <= 1'b0;
            if (state_reg == IDLE && ex_valid_i && ex_misaligned) begin
                valid_reg <= 1'b1;
                rdata_reg <= '0;
                lrd_reg   <= ex_rd_i;
                err_reg   <= MISALIGN;
            end else if (state_reg == WAIT && data_rvalid_i) begin
                valid_reg <= 1'b1;
                lrd_reg   <= rd_reg;
                if (data_err_i) begin
                    rdata_reg <= '0;
                    err_reg   <= BUS;
                end else begin
                    rdata_reg <= we_reg ? '0 : load_result;
                    err_reg   <= NONE;
                end
            end
        end
    end

    assign busy_o       = (state_reg != IDLE);
    assign data_req_o   = (state_reg == REQ);
    assign data_addr_o  = {addr_reg[ADDR_W-1:2], 2'b00};
    assign data_we_o    = we_reg;
    assign data_be_o    = be_reg;
    assign data_wdata_o = wdata_reg;

    assign lsu_valid_o  = valid_reg;
    assign lsu_rdata_o  = rdata_reg;
    assign lsu_rd_o     = lrd_reg;
    assign lsu_err_o    = err_reg;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a reference model predicts bus values and
// completions; one negedge process compares the DUT every cycle.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    lsu_op_e     ex_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        busy_o;
    logic        data_req_o;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;
    logic        lsu_valid_o;
    logic [31:0] lsu_rdata_o;
    logic [4:0]  lsu_rd_o;
    logic [1:0]  lsu_err_o;

    lsu #(.ADDR_W(32), .XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid_i    (ex_valid),
        .ex_op_i       (ex_op),
        .ex_addr_i     (ex_addr),
        .ex_wdata_i    (ex_wdata),
        .ex_rd_i       (ex_rd),
        .busy_o        (busy_o),
        .data_req_o    (data_req_o),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_gnt_i    (data_gnt),
        .data_rvalid_i (data_rvalid),
        .data_rdata_i  (data_rdata),
        .data_err_i    (data_err),
        .lsu_valid_o   (lsu_valid_o),
        .lsu_rdata_o   (lsu_rdata_o),
        .lsu_rd_o      (lsu_rd_o),
        .lsu_err_o     (lsu_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input lsu_op_e op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            default:     return 4;
        endcase
    endfunction

    function automatic bit m_store(input lsu_op_e op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic bit m_misaligned(input lsu_op_e op, input logic [31:0] addr);
        return (addr % nbytes(op)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input lsu_op_e op, input logic [31:0] addr);
        int b;
        b = ((1 << nbytes(op)) - 1) << (addr % 4);
        return b[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input lsu_op_e op, input logic [31:0] w);
        case (nbytes(op))
            1:       return (w & 32'h000000FF) * 32'h01010101;
            2:       return (w & 32'h0000FFFF) * 32'h00010001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_result(input lsu_op_e op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int     n;
        longint v;
        n = nbytes(op);
        if (m_store(op)) return 32'h0;
        v = longint'(rdata >> (8 * (addr % 4))) & ((64'd1 << (8 * n)) - 1);
        if ((op == LB || op == LH) && v >= longint'(64'd1 << (8 * n - 1)))
            v = v - longint'(64'd1 << (8 * n));
        return v[31:0];
    endfunction

    typedef struct {
        int          at;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [1:0]  err;
    } exp_t;

    exp_t        expq[$];
    logic        exp_req  = 1'b0;
    logic        exp_busy = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [3:0]  exp_be   = '0;
    logic        exp_we   = 1'b0;
    logic [31:0] exp_wd   = '0;

    // Last observed values, for the hand-computed pins below.
    logic [31:0] seen_addr, seen_wdata, last_rdata;
    logic [3:0]  seen_be;
    logic        seen_we;
    logic [4:0]  last_rd;
    logic [1:0]  last_err;
    int          last_vcyc;
    int          op_start;
    bit          due;

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        due = (expq.size() > 0) && (expq[0].at == cyc);
        check("busy", 32'(busy_o), 32'(exp_busy));
        check("req", 32'(data_req_o), 32'(exp_req));
        check("valid", 32'(lsu_valid_o), 32'(due));
        if (due && lsu_valid_o) begin
            check("rdata", lsu_rdata_o, expq[0].rdata);
            check("rd", 32'(lsu_rd_o), 32'(expq[0].rd));
            check("err", 32'(lsu_err_o), 32'(expq[0].err));
            last_rdata = lsu_rdata_o;
            last_rd    = lsu_rd_o;
            last_err   = lsu_err_o;
            last_vcyc  = cyc;
        end
        if (due) void'(expq.pop_front());
        if (data_req_o && exp_req) begin
            check("addr", data_addr_o, exp_addr);
            check("be", 32'(data_be_o), 32'(exp_be));
            check("we", 32'(data_we_o), 32'(exp_we));
            if (exp_we) check("wdata", data_wdata_o, exp_wd);
            seen_addr  = data_addr_o;
            seen_be    = data_be_o;
            seen_we    = data_we_o;
            seen_wdata = data_wdata_o;
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input lsu_op_e op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input int gstall, input int rstall,
                          input logic [31:0] rdata, input bit err, input bit gap);
        exp_t e;
        bit   mis;
        mis      = m_misaligned(op, addr);
        op_start = cyc;
        ex_valid = 1'b1;
        ex_op    = op;
        ex_addr  = addr;
        ex_wdata = wd;
        ex_rd    = rd;
        e.at     = cyc + (mis ? 1 : 3 + gstall + rstall);
        e.rd     = rd;
        e.err    = mis ? 2'd1 : (err ? 2'd2 : 2'd0);
        e.rdata  = (mis || err) ? 32'h0 : m_result(op, addr, rdata);
        expq.push_back(e);
        if (!mis) begin
            exp_addr = addr & ~32'h3;
            exp_be   = m_be(op, addr);
            exp_we   = m_store(op);
            exp_wd   = m_wdata(op, wd);
        end
        step();
        ex_valid = 1'b0;
        if (!mis) begin
            exp_req  = 1'b1;
            exp_busy = 1'b1;
            repeat (gstall) step();
            data_gnt = 1'b1;
            step();
            data_gnt = 1'b0;
            exp_req  = 1'b0;
            repeat (rstall) step();
            data_rvalid = 1'b1;
            data_rdata  = rdata;
            data_err    = err;
            step();
            data_rvalid = 1'b0;
            data_err    = 1'b0;
            exp_busy    = 1'b0;
        end
        if (gap) step();
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_op = LB; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
        data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0; data_err = 1'b0;
        #3;
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_req", 32'(data_req_o), 32'h0);
        check("rst_we", 32'(data_we_o), 32'h0);
        check("rst_valid", 32'(lsu_valid_o), 32'h0);
        check("rst_be", 32'(data_be_o), 32'h0);
        check("rst_addr", data_addr_o, 32'h0);
        check("rst_wdata", data_wdata_o, 32'h0);
        check("rst_rdata", lsu_rdata_o, 32'h0);
        check("rst_rd", 32'(lsu_rd_o), 32'h0);
        check("rst_err", 32'(lsu_err_o), 32'h0);
        step(); step();
        rst_n = 1'b1;
        step();

        // LW best case
        run_op(LW, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEADBEEF, 1'b0, 1'b1);
        check("lw_addr", seen_addr, 32'h100);
        check("lw_be", 32'(seen_be), 32'hF);
        check("lw_rdata", last_rdata, 32'hDEADBEEF);
        check("lw_rd", 32'(last_rd), 32'd5);
        check("lw_latency", 32'(last_vcyc - op_start), 32'd3);

        // Byte loads
        run_op(LB, 32'h103, 32'h0, 5'd6, 0, 0, 32'h80123456, 1'b0, 1'b1);
        check("lb_rdata", last_rdata, 32'hFFFFFF80);
        check("lb_be", 32'(seen_be), 32'h8);
        run_op(LBU, 32'h103, 32'h0, 5'd7, 0, 0, 32'h80123456, 1'b0, 1'b1);
        check("lbu_rdata", last_rdata, 32'h00000080);

        // Stores
        run_op(SH, 32'h202, 32'h1234ABCD, 5'd8, 0, 0, 32'h0, 1'b0, 1'b1);
        check("sh_addr", seen_addr, 32'h200);
        check("sh_be", 32'(seen_be), 32'hC);
        check("sh_wdata", seen_wdata, 32'hABCDABCD);
        check("sh_we", 32'(seen_we), 32'h1);
        check("sh_rdata", last_rdata, 32'h0);
        run_op(SB, 32'h201, 32'h00000055, 5'd9, 0, 0, 32'h0, 1'b0, 1'b1);
        check("sb_be", 32'(seen_be), 32'h2);
        check("sb_wdata", seen_wdata, 32'h55555555);

        // Misaligned
        run_op(LW, 32'h101, 32'h0, 5'd10, 0, 0, 32'h0, 1'b0, 1'b1);
        check("mis_err", 32'(last_err), 32'h1);
        check("mis_rd", 32'(last_rd), 32'd10);
        check("mis_latency", 32'(last_vcyc - op_start), 32'd1);
        run_op(SH, 32'h203, 32'hFFFF, 5'd11, 0, 0, 32'h0, 1'b0, 1'b1);

        // Grant stall then bus error
        run_op(LH, 32'h106, 32'h0, 5'd12, 3, 2, 32'h12345678, 1'b1, 1'b1);
        check("buserr_err", 32'(last_err), 32'h2);
        check("buserr_rdata", last_rdata, 32'h0);
        check("stall_be", 32'(seen_be), 32'hC);
        check("stall_latency", 32'(last_vcyc - op_start), 32'd8);

        // Model-checked mix, including back-to-back accept on the valid cycle
        run_op(LHU, 32'h102, 32'h0, 5'd13, 1, 0, 32'h80011234, 1'b0, 1'b1);
        check("lhu_rdata", last_rdata, 32'h00008001);
        run_op(LH, 32'h102, 32'h0, 5'd14, 0, 1, 32'hF00D0000, 1'b0, 1'b1);
        check("lh_rdata", last_rdata, 32'hFFFFF00D);
        run_op(LB, 32'h101, 32'h0, 5'd15, 0, 0, 32'h00007F00, 1'b0, 1'b1);
        run_op(SW, 32'h300, 32'hCAFEF00D, 5'd16, 1, 1, 32'h0, 1'b0, 1'b1);
        run_op(LW, 32'h500, 32'h0, 5'd17, 0, 0, 32'h01020304, 1'b0, 1'b0);
        run_op(SB, 32'h503, 32'h000000A5, 5'd18, 0, 0, 32'h0, 1'b0, 1'b0);
        run_op(LHU, 32'h500, 32'h0, 5'd19, 2, 0, 32'h0000BEEF, 1'b0, 1'b1);

        // Reset while waiting for the response, then a stray rvalid
        ex_valid = 1'b1; ex_op = LW; ex_addr = 32'h400; ex_rd = 5'd20;
        step();
        ex_valid = 1'b0; exp_req = 1'b1; exp_busy = 1'b1;
        exp_addr = 32'h400; exp_be = 4'hF; exp_we = 1'b0;
        data_gnt = 1'b1;
        step();
        data_gnt = 1'b0; exp_req = 1'b0;
        rst_n = 1'b0; exp_busy = 1'b0;
        #1;
        check("rstwait_busy", 32'(busy_o), 32'h0);
        check("rstwait_req", 32'(data_req_o), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        data_rvalid = 1'b1; data_rdata = 32'h11111111;
        step();
        data_rvalid = 1'b0;
        step(); step();

        // Reset while requesting drops the request at once
        ex_valid = 1'b1; ex_op = SW; ex_addr = 32'h600; ex_wdata = 32'h77; ex_rd = 5'd21;
        step();
        ex_valid = 1'b0; exp_addr = 32'h600; exp_be = 4'hF; exp_we = 1'b1; exp_wd = 32'h77;
        #1;
        check("rstreq_req_before", 32'(data_req_o), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rstreq_req", 32'(data_req_o), 32'h0);
        check("rstreq_busy", 32'(busy_o), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        data_gnt = 1'b1;
        step();
        data_gnt = 1'b0;
        step();

        // Recovery after reset
        run_op(LW, 32'h104, 32'h0, 5'd22, 0, 0, 32'h0BADF00D, 1'b0, 1'b1);
        check("recover_rdata", last_rdata, 32'h0BADF00D);
        step(); step();

        if (expq.size() != 0) check("pending_completions", 32'(expq.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting at the data-memory end of the execute stage. Takes the effective address computed by the ALU for load and store ops, runs a request/grant/response handshake to data memory, forms byte enables and lane-replicated write data for stores, and extracts and sign- or zero-extends load data. Holds the pipeline via `busy_o` while an access is outstanding.

## Interface
- `ADDR_W`, 32: address width.
- `XLEN`, 32: data width. Fixed at 32 for this block; 4 byte lanes.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `ex_valid_i` in 1: execute stage presents a load/store this cycle.
- `ex_op_i` in `lsu_op_e` (3): LB, LH, LW, LBU, LHU, SB, SH, SW.
- `ex_addr_i` in `ADDR_W`: effective address (ALU result).
- `ex_wdata_i` in 32: store source register (rs2).
- `ex_rd_i` in 5: destination register tag, returned with the result.
- `busy_o` out 1: unit not in IDLE; execute must hold its operands.
- `data_req_o` out 1: memory request.
- `data_addr_o` out `ADDR_W`: word-aligned address, `{addr[31:2],2'b00}`.
- `data_we_o` out 1: 1 = store.
- `data_be_o` out 4: byte enables.
- `data_wdata_o` out 32: lane-replicated store data.
- `data_gnt_i` in 1: memory accepted the request.
- `data_rvalid_i` in 1: response valid.
- `data_rdata_i` in 32: load data.
- `data_err_i` in 1: bus error, qualified by `data_rvalid_i`.
- `lsu_valid_o` out 1: one-cycle completion pulse.
- `lsu_rdata_o` out 32: extended load result (0 for stores).
- `lsu_rd_o` out 5: tag of the completing op.
- `lsu_err_o` out 2: 0 none, 1 misaligned, 2 bus error.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - With `ex_valid_i`, latch op, addr, wdata and rd.
  - Aligned access: go to REQ.
  - Misaligned access: stay in IDLE and pulse `lsu_valid_o` next cycle with `lsu_err_o`=1. No memory request is issued.
  - Misaligned is halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
- REQ:
  - `data_req_o`=1; addr, we, be and wdata come from registers and stay stable until granted.
  - On `data_gnt_i`, go to WAIT.
- WAIT:
  - On `data_rvalid_i`, go to IDLE and register the result.
  - `lsu_valid_o` pulses the following cycle.
  - `data_err_i` sets `lsu_err_o`=2 and forces `lsu_rdata_o`=0.
- Stores also wait for `data_rvalid_i`, which acts as the write acknowledge.
- Byte enables, with o = `addr[1:0]`:
  - SB: `be = 1<<o`, `wdata = {4{b}}`.
  - SH: `be = 4'b0011<<o`, `wdata = {2{h}}`.
  - SW: `be = 4'hF`.
  - Loads drive `be` as for the matching store width.
- Load extract: lane = `rdata >> (8*o)`.
  - LB/LH: sign-extend bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- `busy_o` = (state≠IDLE). A new `ex_valid_i` is accepted only in IDLE; it is ignored otherwise.
- `data_rvalid_i` outside WAIT and `data_gnt_i` outside REQ are ignored.

## Timing
- Reset values: state=IDLE; `data_req_o`, `data_we_o`, `lsu_valid_o`, `busy_o` = 0; `data_be_o`, `data_addr_o`, `data_wdata_o`, `lsu_rdata_o`, `lsu_rd_o`, `lsu_err_o` = 0.
- Accept at cycle 0. `data_req_o` is high from cycle 1.
- Grant in cycle 1 means WAIT from cycle 2. Memory contract: `data_rvalid_i` earliest one cycle after `data_gnt_i`, in order, one outstanding request.
- `data_rvalid_i` in cycle 2 gives `lsu_valid_o` in cycle 3. Best-case latency is 3 cycles; each grant or response stall adds one cycle.
- Misaligned access: `lsu_valid_o` one cycle after accept; `busy_o` stays 0.
- `lsu_valid_o` is high exactly one cycle. A new op may be accepted in the same cycle that `lsu_valid_o` is high.
- Reset mid-operation drops the request immediately and returns to IDLE. A response arriving after reset is ignored; memory is reset on the same `rst_n`.

## Structure
- Package `lsu_pkg`:
  - `lsu_op_e` enum: LB=0, LH, LW, LBU, LHU, SB, SH, SW.
  - `lsu_err_e`: NONE, MISALIGN, BUS.
  - `lsu_state_e`.
  - Helpers `is_store(op)` and `op_size(op)`.
- Decoder maps ALU load/store op codes onto `lsu_op_e`.
- One sub-module `lsu_load_align` (combinational): rdata, offset and op in; extended 32-bit result out. Used in WAIT.

## Test plan
- **LW:** LW at 0x100 with gnt and rvalid in consecutive cycles, rdata 0xDEADBEEF. Expect req cycle 1, addr 0x100, be F, valid cycle 3, rdata 0xDEADBEEF, rd echoed.
- **Byte loads:** LB at 0x103 with rdata 0x80xxxxxx gives 0xFFFFFF80. LBU at the same address gives 0x00000080.
- **Stores:** SH at 0x202, wdata 0x1234ABCD gives addr 0x200, be 4'b1100, wdata 0xABCDABCD, we=1. SB at 0x201 gives be 4'b0010.
- **Misaligned:** LW at 0x101 gives no `data_req_o`, valid next cycle with err=1, `busy_o` stays 0.
- **Stalls and bus error:** gnt withheld 3 cycles keeps req, addr and be stable. Then rvalid with `data_err_i` gives err=2 and rdata 0.
- **Reset mid-op:** `rst_n` low during WAIT drops `data_req_o`/`busy_o` at once. A subsequent stray rvalid produces no `lsu_valid_o`.
